// File: rtl/bmd_64_tx_engine.sv
// rtl/bmd_64_tx_engine.sv - 64-bit TRN completer TX engine for 1DW MemRd32 CplD
// Reads one DW from endpoint memory and returns it as a 3DW-header CplD over two QWs.

module bmd_64_tx_engine #(
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_rst_i,
  input  logic        req_compl_i,
  output logic        compl_done_o,
  input  logic [2:0]  req_tc_i,
  input  logic        req_td_i,
  input  logic        req_ep_i,
  input  logic [1:0]  req_attr_i,
  input  logic [9:0]  req_len_i,
  input  logic [15:0] req_rid_i,
  input  logic [7:0]  req_tag_i,
  input  logic [7:0]  req_be_i,
  input  logic [10:0] req_addr_i,
  input  logic [15:0] completer_id_i,
  output logic [10:0] rd_addr_o,
  output logic [3:0]  rd_be_o,
  input  logic [31:0] rd_data_i,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  input  logic        trn_tdst_rdy_n,
  input  logic        trn_tbuf_av
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_QW0,
    ST_QW1,
    ST_DONE
  } state_e;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  tc_q, tc_d;
  logic        td_q, td_d;
  logic        ep_q, ep_d;
  logic [1:0]  attr_q, attr_d;
  logic [9:0]  len_q, len_d;
  logic [15:0] rid_q, rid_d;
  logic [7:0]  tag_q, tag_d;
  logic [15:0] cid_q, cid_d;
  logic [10:0] rd_addr_q, rd_addr_d;
  logic [3:0]  rd_be_q, rd_be_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [63:0] trn_td_q, trn_td_d;
  logic        sof_n_q, sof_n_d;
  logic        eof_n_q, eof_n_d;
  logic        src_rdy_n_q, src_rdy_n_d;
  logic        compl_done_q, compl_done_d;

  logic [11:0] byte_cnt;
  logic [1:0]  lo_off;
  logic [63:0] qw0, qw1;
  logic        xfer;
  logic        unused_last_be;

  // Last BE is always zero for a 1DW read and carries no information here.
  assign unused_last_be = ^req_be_i[7:4];

  always_comb begin
    byte_cnt = 12'd1;
    casez (rd_be_q)
      4'b1??1:                   byte_cnt = 12'd4;
      4'b01?1, 4'b1?10:          byte_cnt = 12'd3;
      4'b0011, 4'b0110, 4'b1100: byte_cnt = 12'd2;
      default:                   byte_cnt = 12'd1;
    endcase
    lo_off = 2'b00;
    casez (rd_be_q)
      4'b???1, 4'b0000: lo_off = 2'b00;
      4'b??10:          lo_off = 2'b01;
      4'b?100:          lo_off = 2'b10;
      default:          lo_off = 2'b11;
    endcase
  end

  assign qw0 = {1'b0, 2'b10, 5'b01010, 1'b0, tc_q, 4'b0000,
                td_q, ep_q, attr_q, 2'b00, len_q,
                cid_q, 3'b000, 1'b0, byte_cnt};
  assign qw1 = {rid_q, tag_q, 1'b0, rd_addr_q[4:0], lo_off, rd_data_q};

  assign xfer = !src_rdy_n_q && !trn_tdst_rdy_n;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tc_d         = tc_q;
    td_d         = td_q;
    ep_d         = ep_q;
    attr_d       = attr_q;
    len_d        = len_q;
    rid_d        = rid_q;
    tag_d        = tag_q;
    cid_d        = cid_q;
    rd_addr_d    = rd_addr_q;
    rd_be_d      = rd_be_q;
    rd_data_d    = rd_data_q;
    trn_td_d     = trn_td_q;
    sof_n_d      = sof_n_q;
    eof_n_d      = eof_n_q;
    src_rdy_n_d  = src_rdy_n_q;
    compl_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_compl_i && !init_rst_i) begin
          tc_d      = req_tc_i;
          td_d      = req_td_i;
          ep_d      = req_ep_i;
          attr_d    = req_attr_i;
          len_d     = req_len_i;
          rid_d     = req_rid_i;
          tag_d     = req_tag_i;
          cid_d     = completer_id_i;
          rd_addr_d = req_addr_i;
          rd_be_d   = req_be_i[3:0];
          cnt_d     = LAT;
          state_d   = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (init_rst_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          // Keep re-latching while waiting for credit; the address is stable.
          rd_data_d = rd_data_i;
          if (trn_tbuf_av) begin
            trn_td_d    = qw0;
            sof_n_d     = 1'b0;
            src_rdy_n_d = 1'b0;
            state_d     = ST_QW0;
          end
        end
      end
      ST_QW0: begin
        if (xfer) begin
          trn_td_d = qw1;
          sof_n_d  = 1'b1;
          eof_n_d  = 1'b0;
          state_d  = ST_QW1;
        end
      end
      ST_QW1: begin
        if (xfer) begin
          src_rdy_n_d  = 1'b1;
          eof_n_d      = 1'b1;
          compl_done_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      tc_q         <= 3'd0;
      td_q         <= 1'b0;
      ep_q         <= 1'b0;
      attr_q       <= 2'd0;
      len_q        <= 10'd0;
      rid_q        <= 16'd0;
      tag_q        <= 8'd0;
      cid_q        <= 16'd0;
      rd_addr_q    <= 11'd0;
      rd_be_q      <= 4'd0;
      rd_data_q    <= 32'd0;
      trn_td_q     <= 64'd0;
      sof_n_q      <= 1'b1;
      eof_n_q      <= 1'b1;
      src_rdy_n_q  <= 1'b1;
      compl_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tc_q         <= tc_d;
      td_q         <= td_d;
      ep_q         <= ep_d;
      attr_q       <= attr_d;
      len_q        <= len_d;
      rid_q        <= rid_d;
      tag_q        <= tag_d;
      cid_q        <= cid_d;
      rd_addr_q    <= rd_addr_d;
      rd_be_q      <= rd_be_d;
      rd_data_q    <= rd_data_d;
      trn_td_q     <= trn_td_d;
      sof_n_q      <= sof_n_d;
      eof_n_q      <= eof_n_d;
      src_rdy_n_q  <= src_rdy_n_d;
      compl_done_q <= compl_done_d;
    end
  end

  assign compl_done_o   = compl_done_q;
  assign rd_addr_o      = rd_addr_q;
  assign rd_be_o        = rd_be_q;
  assign trn_td         = trn_td_q;
  assign trn_trem_n     = 8'h00;
  assign trn_tsof_n     = sof_n_q;
  assign trn_teof_n     = eof_n_q;
  assign trn_tsrc_rdy_n = src_rdy_n_q;

endmodule

// File: tb/tb_bmd_64_tx_engine.sv
// tb/tb_bmd_64_tx_engine.sv - directed self-checking bench for bmd_64_tx_engine
// Memory is modelled as a 2-stage read pipeline; a negedge monitor records QW transfers.

module tb_bmd_64_tx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_rst_i;
  logic        req_compl_i;
  logic        compl_done_o;
  logic [2:0]  req_tc_i;
  logic        req_td_i;
  logic        req_ep_i;
  logic [1:0]  req_attr_i;
  logic [9:0]  req_len_i;
  logic [15:0] req_rid_i;
  logic [7:0]  req_tag_i;
  logic [7:0]  req_be_i;
  logic [10:0] req_addr_i;
  logic [15:0] completer_id_i;
  logic [10:0] rd_addr_o;
  logic [3:0]  rd_be_o;
  logic [31:0] rd_data_i;
  logic [63:0] trn_td;
  logic [7:0]  trn_trem_n;
  logic        trn_tsof_n;
  logic        trn_teof_n;
  logic        trn_tsrc_rdy_n;
  logic        trn_tdst_rdy_n;
  logic        trn_tbuf_av;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bmd_64_tx_engine #(.RD_LATENCY(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .init_rst_i     (init_rst_i),
    .req_compl_i    (req_compl_i),
    .compl_done_o   (compl_done_o),
    .req_tc_i       (req_tc_i),
    .req_td_i       (req_td_i),
    .req_ep_i       (req_ep_i),
    .req_attr_i     (req_attr_i),
    .req_len_i      (req_len_i),
    .req_rid_i      (req_rid_i),
    .req_tag_i      (req_tag_i),
    .req_be_i       (req_be_i),
    .req_addr_i     (req_addr_i),
    .completer_id_i (completer_id_i),
    .rd_addr_o      (rd_addr_o),
    .rd_be_o        (rd_be_o),
    .rd_data_i      (rd_data_i),
    .trn_td         (trn_td),
    .trn_trem_n     (trn_trem_n),
    .trn_tsof_n     (trn_tsof_n),
    .trn_teof_n     (trn_teof_n),
    .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
    .trn_tdst_rdy_n (trn_tdst_rdy_n),
    .trn_tbuf_av    (trn_tbuf_av)
  );

  // Endpoint memory: data valid two cycles after the address.
  logic [31:0] mem [0:2047];
  logic [31:0] p1 = 32'd0;
  logic [31:0] p2 = 32'd0;
  always @(posedge clk) begin
    p1 <= mem[rd_addr_o];
    p2 <= p1;
  end
  assign rd_data_i = p2;

  // Record {sof_n, eof_n, td} of each transfer, seen just before the accepting edge.
  logic [65:0] xq[$];
  int          xcyc[$];
  int          done_cnt = 0;
  int          done_cyc = -1;
  always @(negedge clk) begin
    if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
      xq.push_back({trn_tsof_n, trn_teof_n, trn_td});
      xcyc.push_back(cyc);
    end
    if (compl_done_o) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  function automatic logic [65:0] xf(input int i);
    if (i < xq.size()) return xq[i];
    return {66{1'bx}};
  endfunction

  task automatic clear_mon();
    xq.delete();
    xcyc.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic start_req(input logic [15:0] rid, input logic [7:0] tag, input logic [3:0] fbe,
                           input logic [10:0] addr, input logic [2:0] tc, input logic td,
                           input logic ep, input logic [1:0] attr, input logic [15:0] cid);
    @(posedge clk); #1;
    req_rid_i      = rid;
    req_tag_i      = tag;
    req_be_i       = {4'h0, fbe};
    req_addr_i     = addr;
    req_tc_i       = tc;
    req_td_i       = td;
    req_ep_i       = ep;
    req_attr_i     = attr;
    req_len_i      = 10'd1;
    completer_id_i = cid;
    req_compl_i    = 1'b1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (compl_done_o) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req_compl_i = 1'b0;
  endtask

  task automatic wait_src(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!trn_tsrc_rdy_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (trn_tsof_n !== 1'b1) begin n_fail++; $display("FAIL rst_sof: got %b want 1", trn_tsof_n); end
    n_checks++; if (trn_teof_n !== 1'b1) begin n_fail++; $display("FAIL rst_eof: got %b want 1", trn_teof_n); end
    n_checks++; if (trn_tsrc_rdy_n !== 1'b1) begin n_fail++; $display("FAIL rst_src_rdy: got %b want 1", trn_tsrc_rdy_n); end
    n_checks++; if (trn_td !== 64'h0) begin n_fail++; $display("FAIL rst_td: got %h want 0", trn_td); end
    n_checks++; if (trn_trem_n !== 8'h00) begin n_fail++; $display("FAIL rst_trem: got %h want 00", trn_trem_n); end
    n_checks++; if (compl_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", compl_done_o); end
    n_checks++; if ({rd_addr_o, rd_be_o} !== 15'h0) begin n_fail++; $display("FAIL rst_rd: got %h/%h want 0/0", rd_addr_o, rd_be_o); end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (trn_tsrc_rdy_n !== 1'b1) begin n_fail++; $display("FAIL idle_src_rdy: got %b want 1", trn_tsrc_rdy_n); end
  endtask

  task automatic test_basic();
    bit ok;
    clear_mon();
    start_req(16'h0100, 8'h05, 4'hF, 11'h004, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0200);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t1_done_seen: got 0 want 1"); end
    n_checks++; if (xq.size() != 2) begin n_fail++; $display("FAIL t1_xfer_count: got %0d want 2", xq.size()); end
    n_checks++; if (xf(0) !== {2'b01, 64'h4A000001_02000004}) begin n_fail++; $display("FAIL t1_qw0: got %h want %h", xf(0), {2'b01, 64'h4A000001_02000004}); end
    n_checks++; if (xf(1) !== {2'b10, 64'h01000510_DEADBEEF}) begin n_fail++; $display("FAIL t1_qw1: got %h want %h", xf(1), {2'b10, 64'h01000510_DEADBEEF}); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL t1_done_count: got %0d want 1", done_cnt); end
    n_checks++; if (done_cyc != ((xcyc.size() > 1) ? xcyc[1] + 1 : -99)) begin n_fail++; $display("FAIL t1_done_timing: got cycle %0d want one after QW1 transfer", done_cyc); end
    n_checks++; if ({rd_addr_o, rd_be_o} !== {11'h004, 4'hF}) begin n_fail++; $display("FAIL t1_rd_req: got %h/%h want 004/f", rd_addr_o, rd_be_o); end
  endtask

  task automatic test_lower_addr();
    bit ok;
    clear_mon();
    start_req(16'hABCD, 8'h7F, 4'b0100, 11'h3FF, 3'd5, 1'b1, 1'b0, 2'b10, 16'h1234);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t2_done_seen: got 0 want 1"); end
    n_checks++; if (xf(0) !== {2'b01, 64'h4A50A001_12340001}) begin n_fail++; $display("FAIL t2_qw0: got %h want %h", xf(0), {2'b01, 64'h4A50A001_12340001}); end
    n_checks++; if (xf(1) !== {2'b10, 64'hABCD7F7E_CAFEF00D}) begin n_fail++; $display("FAIL t2_qw1: got %h want %h", xf(1), {2'b10, 64'hABCD7F7E_CAFEF00D}); end
    n_checks++; if ({rd_addr_o, rd_be_o} !== {11'h3FF, 4'b0100}) begin n_fail++; $display("FAIL t2_rd_req: got %h/%h want 3ff/4", rd_addr_o, rd_be_o); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    clear_mon();
    start_req(16'h0100, 8'h06, 4'b0110, 11'h010, 3'd7, 1'b0, 1'b1, 2'b01, 16'h0200);
    wait_done(ok1);
    start_req(16'h0100, 8'h07, 4'b1001, 11'h01F, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0200);
    wait_done(ok2);
    n_checks++; if (!(ok1 && ok2)) begin n_fail++; $display("FAIL t3_done_seen: got %b%b want 11", ok1, ok2); end
    n_checks++; if (xq.size() != 4) begin n_fail++; $display("FAIL t3_xfer_count: got %0d want 4", xq.size()); end
    n_checks++; if (xf(0) !== {2'b01, 64'h4A705001_02000002}) begin n_fail++; $display("FAIL t3_a_qw0: got %h want %h", xf(0), {2'b01, 64'h4A705001_02000002}); end
    n_checks++; if (xf(1) !== {2'b10, 64'h01000641_12345678}) begin n_fail++; $display("FAIL t3_a_qw1: got %h want %h", xf(1), {2'b10, 64'h01000641_12345678}); end
    n_checks++; if (xf(2) !== {2'b01, 64'h4A000001_02000004}) begin n_fail++; $display("FAIL t3_b_qw0: got %h want %h", xf(2), {2'b01, 64'h4A000001_02000004}); end
    n_checks++; if (xf(3) !== {2'b10, 64'h0100077C_9ABCDEF0}) begin n_fail++; $display("FAIL t3_b_qw1: got %h want %h", xf(3), {2'b10, 64'h0100077C_9ABCDEF0}); end
    n_checks++; if (done_cnt != 2) begin n_fail++; $display("FAIL t3_done_count: got %0d want 2", done_cnt); end
  endtask

  task automatic test_dst_stall();
    bit ok, okd;
    clear_mon();
    trn_tdst_rdy_n = 1'b1;
    start_req(16'h0100, 8'h08, 4'hF, 11'h005, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0200);
    wait_src(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t4_qw0_start: got src_rdy_n=1 want 0"); end
    n_checks++; if ({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_td} !== {3'b001, 64'h4A000001_02000004}) begin n_fail++; $display("FAIL t4_qw0_hold0: got %h", trn_td); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) trn_tbuf_av = 1'b0;
      if (i == 2) trn_tdst_rdy_n = 1'b0;
      @(negedge clk);
      n_checks++; if ({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_td} !== {3'b001, 64'h4A000001_02000004}) begin n_fail++; $display("FAIL t4_qw0_hold%0d: got %b%b%b %h", i + 1, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_td); end
    end
    @(posedge clk); #1 trn_tdst_rdy_n = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      n_checks++; if ({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_td} !== {3'b010, 64'h01000814_0F0F0F0F}) begin n_fail++; $display("FAIL t4_qw1_hold%0d: got %b%b%b %h", j, trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_td); end
      @(posedge clk); #1;
      if (j == 1) trn_tdst_rdy_n = 1'b0;
    end
    wait_done(okd);
    trn_tbuf_av = 1'b1;
    n_checks++; if (!okd) begin n_fail++; $display("FAIL t4_done_seen: got 0 want 1"); end
    n_checks++; if (xq.size() != 2) begin n_fail++; $display("FAIL t4_xfer_count: got %0d want 2", xq.size()); end
    n_checks++; if (xf(1) !== {2'b10, 64'h01000814_0F0F0F0F}) begin n_fail++; $display("FAIL t4_qw1: got %h want %h", xf(1), {2'b10, 64'h01000814_0F0F0F0F}); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL t4_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_tbuf_av();
    bit ok;
    int early;
    clear_mon();
    early = 0;
    trn_tbuf_av = 1'b0;
    start_req(16'h0100, 8'h09, 4'hF, 11'h006, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0200);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (trn_tsrc_rdy_n !== 1'b1) early++;
    end
    n_checks++; if (early != 0) begin n_fail++; $display("FAIL t5_no_credit_hold: got %0d cycles with src_rdy_n=0 want 0", early); end
    @(posedge clk); #1 trn_tbuf_av = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if ({trn_tsrc_rdy_n, trn_tsof_n} !== 2'b00) begin n_fail++; $display("FAIL t5_start_on_credit: got %b%b want 00", trn_tsrc_rdy_n, trn_tsof_n); end
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t5_done_seen: got 0 want 1"); end
    n_checks++; if (xf(1) !== {2'b10, 64'h01000918_55AA55AA}) begin n_fail++; $display("FAIL t5_qw1: got %h want %h", xf(1), {2'b10, 64'h01000918_55AA55AA}); end
  endtask

  task automatic test_init_rst();
    bit ok, okd;
    clear_mon();
    start_req(16'h0100, 8'h0C, 4'hF, 11'h009, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0200);
    @(posedge clk); #1 init_rst_i = 1'b1;
    @(posedge clk); #1;
    init_rst_i  = 1'b0;
    req_compl_i = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (xq.size() != 0) begin n_fail++; $display("FAIL t6_rdwait_abort_xfers: got %0d want 0", xq.size()); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL t6_rdwait_abort_done: got %0d want 0", done_cnt); end

    clear_mon();
    trn_tdst_rdy_n = 1'b1;
    start_req(16'h0100, 8'h0A, 4'hF, 11'h007, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0200);
    wait_src(ok);
    @(posedge clk); #1 init_rst_i = 1'b1;
    @(posedge clk); #1 trn_tdst_rdy_n = 1'b0;
    wait_done(okd);
    init_rst_i = 1'b0;
    n_checks++; if (!(ok && okd)) begin n_fail++; $display("FAIL t6_qw0_init_done: got %b%b want 11", ok, okd); end
    n_checks++; if (xf(0) !== {2'b01, 64'h4A000001_02000004}) begin n_fail++; $display("FAIL t6_qw0_init_qw0: got %h want %h", xf(0), {2'b01, 64'h4A000001_02000004}); end
    n_checks++; if (xf(1) !== {2'b10, 64'h01000A1C_A5A5A5A5}) begin n_fail++; $display("FAIL t6_qw0_init_qw1: got %h want %h", xf(1), {2'b10, 64'h01000A1C_A5A5A5A5}); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL t6_qw0_init_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_async_rst();
    bit ok;
    clear_mon();
    start_req(16'h0100, 8'h0B, 4'hF, 11'h008, 3'd0, 1'b0, 1'b0, 2'd0, 16'h0200);
    wait_src(ok);
    @(posedge clk); #1;
    trn_tdst_rdy_n = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, compl_done_o, rd_addr_o, rd_be_o} !== {64'h0, 8'h00, 3'b111, 1'b0, 11'h0, 4'h0}) begin n_fail++; $display("FAIL t6_rst_qw1: got td=%h sof=%b eof=%b src=%b done=%b addr=%h be=%h", trn_td, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, compl_done_o, rd_addr_o, rd_be_o); end
    @(posedge clk); #1;
    req_compl_i    = 1'b0;
    trn_tdst_rdy_n = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++; if (!ok || xq.size() != 1) begin n_fail++; $display("FAIL t6_rst_xfers: got %0d want 1", xq.size()); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL t6_rst_done_count: got %0d want 0", done_cnt); end
  endtask

  initial begin
    rst            = 1'b1;
    init_rst_i     = 1'b0;
    req_compl_i    = 1'b0;
    req_tc_i       = 3'd0;
    req_td_i       = 1'b0;
    req_ep_i       = 1'b0;
    req_attr_i     = 2'd0;
    req_len_i      = 10'd0;
    req_rid_i      = 16'd0;
    req_tag_i      = 8'd0;
    req_be_i       = 8'd0;
    req_addr_i     = 11'd0;
    completer_id_i = 16'd0;
    trn_tdst_rdy_n = 1'b0;
    trn_tbuf_av    = 1'b1;
    for (int i = 0; i < 2048; i++) mem[i] = 32'h11110000 + i;
    mem[11'h004] = 32'hDEADBEEF;
    mem[11'h3FF] = 32'hCAFEF00D;
    mem[11'h010] = 32'h12345678;
    mem[11'h01F] = 32'h9ABCDEF0;
    mem[11'h005] = 32'h0F0F0F0F;
    mem[11'h006] = 32'h55AA55AA;
    mem[11'h007] = 32'hA5A5A5A5;
    repeat (3) @(posedge clk);
    test_reset();
    test_basic();
    test_lower_addr();
    test_back_to_back();
    test_dst_stall();
    test_tbuf_av();
    test_init_rst();
    test_async_rst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
